// File: rtl/sdram_rd_collect.sv
// Collects one SDRAM read burst into a FWFT FIFO and hands it to the host over valid/ready.
// Optional MARKER_STRIP_EN: the burst-stop marker word ends the burst but is neither stored nor counted.
module sdram_rd_collect #(
    parameter int AW        = 4,
    parameter int MAX_BURST = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_start,
    input  logic        rd_valid,
    input  logic [15:0] rd_data,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        burst_done,
    output logic [8:0]  word_cnt,
    output logic        overflow
);

    localparam logic [AW:0] DEPTH   = (AW+1)'(1 << AW);
    localparam logic [8:0]  MAX_CNT = 9'(MAX_BURST);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [15:0]     r_mem [2**AW];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic [8:0]      r_word_cnt;
    logic            r_overflow;

    logic            w_accept;
    logic            w_marker;
    logic            w_keep;
    logic [8:0]      w_cnt_inc;
    logic            w_term;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;

    assign w_accept  = (r_state == S_COLLECT) && rd_valid;
    assign w_marker  = rd_data[15];
`ifdef MARKER_STRIP_EN
    assign w_keep    = w_accept && !w_marker;
`else
    assign w_keep    = w_accept;
`endif
    assign w_cnt_inc = r_word_cnt + 9'd1;
    // Marker and limit both end the burst; a dropped word still terminates it.
    assign w_term    = (w_accept && w_marker) || (w_keep && (w_cnt_inc == MAX_CNT));

    assign w_full    = (r_count == DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_pop     = !w_empty && out_ready;
    assign w_push    = w_keep && (!w_full || w_pop);
    assign w_drop    = w_keep && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (rd_start) w_state_nxt = S_COLLECT;
            S_COLLECT: if (w_term)   w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_word_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (r_state == S_IDLE && rd_start) begin
                r_word_cnt <= '0;
            end else if (w_keep) begin
                r_word_cnt <= w_cnt_inc;
            end
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    // Storage carries no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= rd_data;
    end

    assign out_valid  = !w_empty;
    assign out_data   = w_empty ? 16'h0000 : r_mem[r_rd_ptr];
    assign busy       = (r_state == S_COLLECT);
    assign burst_done = (r_state == S_DONE);
    assign word_cnt   = r_word_cnt;
    assign overflow   = r_overflow;

endmodule

// File: doc/sdram_rd_collect.md
Name: sdram_rd_collect

Overview:
- Downstream consumer of the SDRAM data-path read output (16-bit read word plus bit-15 burst-stop marker).
- Collects one read burst into a small first-word-fall-through FIFO and terminates the burst on the stop marker or a length limit.
- Presents the data to the host/readout logic over a valid/ready handshake and reports burst completion, word count and overflow.

Parameters:
- AW, 4, FIFO address width; depth = 2**AW words.
- MAX_BURST, 256, burst length limit in words (1..511); a 9-bit counter bounds it.

Ports:
- clk  in  1  system clock, shared with the SDRAM controller.
- rst  in  1  synchronous reset, active-high.
- rd_start  in  1  one-cycle pulse; arms collection of a new burst.
- rd_valid  in  1  rd_data holds a valid read word this cycle.
- rd_data  in  16  read word from the SDRAM data path; bit 15 = burst-stop marker.
- out_data  out  16  FIFO head word.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head word when out_valid=1.
- busy  out  1  collecting (state COLLECT).
- burst_done  out  1  one-cycle pulse when a burst terminates.
- word_cnt  out  9  words accepted in the current/last burst.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All state updates on posedge clk.
- Reset values: busy=0, burst_done=0, word_cnt=0, overflow=0, out_valid=0, out_data=0. FIFO pointers cleared; memory contents are don't-care.
- States:
  - IDLE: rd_start moves to COLLECT, clears word_cnt, leaves overflow unchanged. rd_valid is ignored.
  - COLLECT: each rd_valid is an accepted word; word_cnt increments.
  - COLLECT to DONE: when an accepted word has rd_data[15]=1, or the accepted word brings word_cnt to MAX_BURST. The marker wins if both hold; the result is the same.
  - DONE: lasts one cycle with burst_done=1, then returns to IDLE.
- rd_start in COLLECT or DONE is ignored.
- Reset mid-burst returns to IDLE and flushes the FIFO.
- FIFO write: an accepted word is written if not full. If full and not popping in the same cycle, the word is dropped and overflow is set.
  - A dropped word still counts in word_cnt and still terminates the burst if it is a marker or the limit word.
- Full with simultaneous pop: the write succeeds and occupancy is unchanged.
- FIFO read: a pop occurs on out_valid & out_ready. out_data is the head word, with zero read latency (FWFT).
- Latency: a word written on edge N gives out_valid=1 after edge N, i.e. it is visible in cycle N+1.
- Empty with simultaneous write: out_valid rises next cycle. No bypass path.
- Occupancy counter: AW+1 bits. full = count==2**AW; empty = count==0. Pointers wrap modulo 2**AW.
- out_ready with out_valid=0: no effect.
- overflow is cleared only by rst.

Optional Feature:
- Macro: MARKER_STRIP_EN.
- Defined: the marker word (rd_data[15]=1) terminates the burst but is not written to the FIFO and not counted in word_cnt. A marker arriving when the FIFO is full does not set overflow.
- Undefined: the marker word is written to the FIFO and counted like any data word.

Test Plan:
- Basic burst: rst, rd_start, 5 words 0x0001..0x0004 then 0x8005, out_ready=1.
  - Macro undefined: out sequence 0x0001..0x8005, word_cnt=5, one burst_done pulse, busy=0 afterwards.
  - Macro defined: out sequence 0x0001..0x0004, word_cnt=4.
- Limit: MAX_BURST=8, 10 words with bit15=0 → burst_done after the 8th word, word_cnt=8, words 9-10 not written, FIFO holds 8 words.
- Overflow: AW=2, out_ready=0, 6 words, last is 0x8006 → FIFO holds the first 4, overflow=1, word_cnt=6. Then out_ready=1 drains 4 words and out_valid drops.
- Full with simultaneous pop: AW=2, fill 4 words, then a write and out_ready=1 in the same cycle → no overflow, count stays 4, order preserved.
- Reset mid-burst: rst asserted after 3 of 6 words → out_valid=0, word_cnt=0, busy=0 next cycle. Words arriving without rd_start are ignored.
- Stray input: rd_valid with 0x1234 in IDLE and rd_start during COLLECT → no FIFO write, word_cnt unaffected.
